// File: rtl/vram_arbiter.sv
// vram_arbiter: screen RAM arbiter, video reads win every clock, CPU fills the gaps (VRAM_CONTENTION_EN adds a ULA contention gate)
module vram_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic        vrd,
  input  logic        vcn,
  input  logic [12:0] va,
  output logic [7:0]  vd,
  input  logic        cpuReq,
  input  logic        cpuWr,
  input  logic [13:0] cpuA,
  input  logic [7:0]  cpuDi,
  output logic [7:0]  cpuDo,
  output logic        cpuAck,
  output logic        cpuWait,
  output logic [13:0] memA,
  output logic        memWe,
  output logic [7:0]  memD,
  input  logic [7:0]  memQ
);
  typedef enum logic [1:0] {IDLE, READ, ACK} state_t;
  state_t state;
  logic serviced, videoPend, videoIssue, cpuIssue, gateOpen;
`ifdef VRAM_CONTENTION_EN
  assign gateOpen = !vcn;
`else
  assign gateOpen = vcn || !vcn;
`endif
  assign videoIssue = ce && vrd;
  assign cpuIssue = reset && state == IDLE && cpuReq && !serviced && !videoIssue && gateOpen;
  assign memA = cpuIssue ? cpuA : {1'b0, va};
  assign memWe = cpuIssue && cpuWr;
  assign memD = cpuIssue ? cpuDi : 8'h00;
  assign cpuAck = state == ACK;
  assign cpuWait = cpuReq && state != ACK && !serviced;
  // video data lands one clock after its address was issued
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      videoPend <= 1'b0;
      vd <= 8'h00;
    end else begin
      videoPend <= videoIssue;
      if (videoPend) vd <= memQ;
    end
  // CPU access sequencer; serviced blocks a held request from running twice
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      serviced <= 1'b0;
      cpuDo <= 8'h00;
    end else begin
      case (state)
        IDLE: if (cpuIssue) state <= cpuWr ? ACK : READ;
              else if (!cpuReq) serviced <= 1'b0;
        READ: begin
          cpuDo <= memQ;
          state <= ACK;
        end
        ACK: begin
          serviced <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed checks of video priority, CPU access timing, contention and reset
module tb_vram_arbiter;
  logic clock = 1'b0, reset = 1'b0, ce = 1'b0, vrd = 1'b0, vcn = 1'b0;
  logic [12:0] va = '0;
  logic [7:0] vd, cpuDo, cpuDi = '0, memD, memQ;
  logic cpuReq = 1'b0, cpuWr = 1'b0, cpuAck, cpuWait, memWe;
  logic [13:0] cpuA = '0, memA;
  logic loadEn = 1'b0;
  logic [13:0] loadA = '0;
  logic [7:0] loadD = '0;
  logic [7:0] mem [0:16383];
  int nCmp = 0, nBad = 0;

  vram_arbiter dut (
    .clock(clock), .reset(reset), .ce(ce), .vrd(vrd), .vcn(vcn), .va(va), .vd(vd),
    .cpuReq(cpuReq), .cpuWr(cpuWr), .cpuA(cpuA), .cpuDi(cpuDi), .cpuDo(cpuDo),
    .cpuAck(cpuAck), .cpuWait(cpuWait), .memA(memA), .memWe(memWe), .memD(memD), .memQ(memQ)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (loadEn) mem[loadA] <= loadD;
    else if (memWe) mem[memA] <= memD;
    memQ <= mem[memA];
  end

  task automatic load(input logic [13:0] a, input logic [7:0] d);
    @(negedge clock);
    loadEn = 1'b1; loadA = a; loadD = d;
    @(negedge clock);
    loadEn = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      ce = 1'b0; vrd = 1'b0; cpuReq = 1'b0;
    end
  endtask

  task automatic test_reset;
    @(negedge clock);
    reset = 1'b0; cpuReq = 1'b0; va = 13'h0042;
    #1;
    nCmp++; if (vd !== 8'h00) begin nBad++; $display("FAIL reset_vd got %h want 00", vd); end
    nCmp++; if (cpuDo !== 8'h00) begin nBad++; $display("FAIL reset_cpuDo got %h want 00", cpuDo); end
    nCmp++; if (cpuAck !== 1'b0) begin nBad++; $display("FAIL reset_cpuAck got %b want 0", cpuAck); end
    nCmp++; if (memWe !== 1'b0) begin nBad++; $display("FAIL reset_memWe got %b want 0", memWe); end
    @(negedge clock);
    cpuReq = 1'b1; cpuWr = 1'b1; cpuA = 14'h0100;
    #1;
    nCmp++; if (cpuWait !== 1'b1) begin nBad++; $display("FAIL reset_wait got %b want 1", cpuWait); end
    nCmp++; if (memA !== 14'h0042) begin nBad++; $display("FAIL reset_memA got %h want 0042", memA); end
    nCmp++; if (memWe !== 1'b0) begin nBad++; $display("FAIL reset_memWe_req got %b want 0", memWe); end
    @(negedge clock);
    cpuReq = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    idle(2);
  endtask

  task automatic test_video;
    load(14'h0123, 8'hA5);
    @(negedge clock);
    ce = 1'b1; vrd = 1'b1; va = 13'h0123;
    #1;
    nCmp++; if (memA !== 14'h0123) begin nBad++; $display("FAIL video_memA got %h want 0123", memA); end
    nCmp++; if (memWe !== 1'b0) begin nBad++; $display("FAIL video_memWe got %b want 0", memWe); end
    @(negedge clock);
    ce = 1'b0; vrd = 1'b0; va = 13'h0000;
    @(posedge clock); #1;
    nCmp++; if (vd !== 8'hA5) begin nBad++; $display("FAIL video_vd got %h want a5", vd); end
    idle(2);
  endtask

  task automatic test_write;
    @(negedge clock);
    cpuReq = 1'b1; cpuWr = 1'b1; cpuA = 14'h1800; cpuDi = 8'h3C;
    #1;
    nCmp++; if (memWe !== 1'b1) begin nBad++; $display("FAIL wr_memWe got %b want 1", memWe); end
    nCmp++; if (memA !== 14'h1800) begin nBad++; $display("FAIL wr_memA got %h want 1800", memA); end
    nCmp++; if (memD !== 8'h3C) begin nBad++; $display("FAIL wr_memD got %h want 3c", memD); end
    nCmp++; if (cpuAck !== 1'b0) begin nBad++; $display("FAIL wr_ack_early got %b want 0", cpuAck); end
    @(posedge clock); #1;
    nCmp++; if (cpuAck !== 1'b1) begin nBad++; $display("FAIL wr_ack got %b want 1", cpuAck); end
    nCmp++; if (memWe !== 1'b0) begin nBad++; $display("FAIL wr_memWe_once got %b want 0", memWe); end
    nCmp++; if (cpuWait !== 1'b0) begin nBad++; $display("FAIL wr_wait_ack got %b want 0", cpuWait); end
    @(negedge clock);
    cpuReq = 1'b0;
    @(posedge clock); #1;
    nCmp++; if (cpuAck !== 1'b0) begin nBad++; $display("FAIL wr_ack_pulse got %b want 0", cpuAck); end
    nCmp++; if (mem[14'h1800] !== 8'h3C) begin nBad++; $display("FAIL wr_ram got %h want 3c", mem[14'h1800]); end
    idle(2);
  endtask

  task automatic test_read;
    @(negedge clock);
    cpuReq = 1'b1; cpuWr = 1'b0; cpuA = 14'h1800;
    #1;
    nCmp++; if (memA !== 14'h1800) begin nBad++; $display("FAIL rd_memA got %h want 1800", memA); end
    nCmp++; if (memWe !== 1'b0) begin nBad++; $display("FAIL rd_memWe got %b want 0", memWe); end
    @(posedge clock); #1;
    nCmp++; if (cpuAck !== 1'b0) begin nBad++; $display("FAIL rd_ack_early got %b want 0", cpuAck); end
    nCmp++; if (cpuWait !== 1'b1) begin nBad++; $display("FAIL rd_wait got %b want 1", cpuWait); end
    @(posedge clock); #1;
    nCmp++; if (cpuAck !== 1'b1) begin nBad++; $display("FAIL rd_ack got %b want 1", cpuAck); end
    nCmp++; if (cpuDo !== 8'h3C) begin nBad++; $display("FAIL rd_cpuDo got %h want 3c", cpuDo); end
    idle(3);
  endtask

  task automatic test_collision;
    load(14'h0200, 8'h5A);
    load(14'h1000, 8'hC3);
    @(negedge clock);
    ce = 1'b1; vrd = 1'b1; va = 13'h0200; cpuReq = 1'b1; cpuWr = 1'b0; cpuA = 14'h1000;
    #1;
    nCmp++; if (memA !== 14'h0200) begin nBad++; $display("FAIL col_video_memA got %h want 0200", memA); end
    nCmp++; if (cpuWait !== 1'b1) begin nBad++; $display("FAIL col_wait got %b want 1", cpuWait); end
    @(negedge clock);
    ce = 1'b0; vrd = 1'b0;
    #1;
    nCmp++; if (memA !== 14'h1000) begin nBad++; $display("FAIL col_cpu_memA got %h want 1000", memA); end
    @(posedge clock); #1;
    nCmp++; if (vd !== 8'h5A) begin nBad++; $display("FAIL col_vd got %h want 5a", vd); end
    @(posedge clock); #1;
    nCmp++; if (cpuAck !== 1'b1) begin nBad++; $display("FAIL col_ack got %b want 1", cpuAck); end
    nCmp++; if (cpuDo !== 8'hC3) begin nBad++; $display("FAIL col_cpuDo got %h want c3", cpuDo); end
    idle(3);
  endtask

  task automatic test_contention;
    int writes, firstWe, waitLow;
    writes = 0; firstWe = -1; waitLow = 0;
    cpuWr = 1'b1; cpuA = 14'h0005; cpuDi = 8'h77; va = 13'h0300;
    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      cpuReq = 1'b1; vcn = 1'b1; ce = (i % 2 == 0); vrd = (i % 2 == 0);
      #1;
      if (memWe) begin writes++; if (firstWe < 0) firstWe = i; end
      if (!cpuWait) waitLow++;
    end
    @(negedge clock);
    vcn = 1'b0; ce = 1'b0; vrd = 1'b0;
    #1;
`ifdef VRAM_CONTENTION_EN
    nCmp++; if (writes !== 0) begin nBad++; $display("FAIL cont_writes got %0d want 0", writes); end
    nCmp++; if (waitLow !== 0) begin nBad++; $display("FAIL cont_wait_low got %0d want 0", waitLow); end
    nCmp++; if (memWe !== 1'b1) begin nBad++; $display("FAIL cont_release_memWe got %b want 1", memWe); end
`else
    nCmp++; if (writes !== 1) begin nBad++; $display("FAIL uncont_writes got %0d want 1", writes); end
    nCmp++; if (firstWe !== 1) begin nBad++; $display("FAIL uncont_first got %0d want 1", firstWe); end
    nCmp++; if (memWe !== 1'b0) begin nBad++; $display("FAIL uncont_no_repeat got %b want 0", memWe); end
`endif
    idle(4);
    nCmp++; if (mem[14'h0005] !== 8'h77) begin nBad++; $display("FAIL cont_ram got %h want 77", mem[14'h0005]); end
  endtask

  task automatic test_reset_mid;
    int acks;
    acks = 0;
    @(negedge clock);
    cpuReq = 1'b1; cpuWr = 1'b0; cpuA = 14'h1800;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    nCmp++; if (cpuAck !== 1'b0) begin nBad++; $display("FAIL rst_mid_ack got %b want 0", cpuAck); end
    nCmp++; if (cpuDo !== 8'h00) begin nBad++; $display("FAIL rst_mid_cpuDo got %h want 00", cpuDo); end
    @(posedge clock); #1;
    nCmp++; if (cpuAck !== 1'b0) begin nBad++; $display("FAIL rst_mid_ack_hold got %b want 0", cpuAck); end
    @(negedge clock);
    reset = 1'b1;
    #1;
    nCmp++; if (memA !== 14'h1800) begin nBad++; $display("FAIL rst_mid_reissue got %h want 1800", memA); end
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      if (cpuAck) acks++;
    end
    nCmp++; if (acks !== 1) begin nBad++; $display("FAIL rst_mid_acks got %0d want 1", acks); end
    nCmp++; if (cpuDo !== 8'h3C) begin nBad++; $display("FAIL rst_mid_data got %h want 3c", cpuDo); end
    idle(2);
  endtask

  initial begin
    test_reset;
    test_video;
    test_write;
    test_read;
    test_collision;
    test_contention;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
